hazard_scoreboard: RTL and testbench

Parametrised per-register scoreboard for the decode stage. It replaces fixed EXE/MEM destination comparison with a pending-write table and per-register latency countdowns, so it covers variable-latency units (loads, multiply, divide) and any number of source operands. It raises `stall` for RAW and WAW hazards and flags sources that must take their value from the bypass network. It sits beside the register file in ID, is written at issue and cleared at write-back.

---
 rtl/hazard_scoreboard_pkg.sv | 10 +
 rtl/hazard_scoreboard_entry.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 92 +++++++++
 tb/tb_hazard_scoreboard.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard.
// Forwarding readiness is enabled by defining HAZARD_FORWARD_EN (undefined by default).
package hazard_scoreboard_pkg;

    localparam int unsigned REG_ADDR_SIZE = 4;
    localparam int unsigned DEF_CNT_W     = 3;
    localparam int unsigned DEF_NUM_SRC   = 2;
    localparam int unsigned DEF_NUM_REGS  = 32;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: pending flag, variable-latency flag and forwarding countdown.
// With HAZARD_FORWARD_EN a known-latency entry is ready once its countdown reaches 0.
module scoreboard_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic             clear,
    input  logic [CNT_W-1:0] lat,
    output logic             pending,
    output logic             varlat,
    output logic [CNT_W-1:0] cnt,
    output logic             rdy
);

    // Issue takes priority over a same-cycle write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            varlat  <= 1'b0;
            cnt     <= '0;
        end else if (issue) begin
            pending <= 1'b1;
            varlat  <= (lat == '0);
            cnt     <= (lat == '0) ? '0 : lat - CNT_W'(1);
        end else if (clear) begin
            pending <= 1'b0;
            varlat  <= 1'b0;
            cnt     <= '0;
        end else if (pending && !varlat && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifdef HAZARD_FORWARD_EN
    assign rdy = !pending || (!varlat && cnt == '0);
`else
    assign rdy = !pending;
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard raising stall on RAW/WAW hazards in ID.
// HAZARD_FORWARD_EN enables countdown-based readiness and fwd_hit; otherwise fwd_hit is 0.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
    parameter int unsigned REG_ADDR_W = REG_ADDR_SIZE + 1,
    parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_valid,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_rd_valid,
    input  logic [CNT_W-1:0]              id_lat,
    input  logic                          flush,
    input  logic                          wb_valid,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    output logic                          stall,
    output logic [NUM_SRC-1:0]            fwd_hit,
    output logic [NUM_REGS-1:0]           pending_vec
);

    logic [NUM_REGS-1:0]   pend_tab;
    logic [NUM_REGS-1:0]   varlat_tab;
    logic [NUM_REGS-1:0]   rdy_tab;
    logic [CNT_W-1:0]      cnt_tab [NUM_REGS];
    logic [REG_ADDR_W-1:0] rs;
    logic [NUM_SRC-1:0]    fwd;
    logic                  raw;
    logic                  waw;
    logic                  issue;

    // x0 is hard-wired: never pending, always ready.
    assign pend_tab[0]   = 1'b0;
    assign varlat_tab[0] = 1'b0;
    assign rdy_tab[0]    = 1'b1;
    assign cnt_tab[0]    = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic ent_issue;
        logic ent_clear;

        assign ent_issue = issue && (id_rd == REG_ADDR_W'(r));
        assign ent_clear = wb_valid && (wb_rd == REG_ADDR_W'(r));

        scoreboard_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk     (clk),
            .reset   (reset),
            .issue   (ent_issue),
            .clear   (ent_clear),
            .lat     (id_lat),
            .pending (pend_tab[r]),
            .varlat  (varlat_tab[r]),
            .cnt     (cnt_tab[r]),
            .rdy     (rdy_tab[r])
        );
    end

    // Source operand checks: RAW hazard and bypass selection.
    always_comb begin
        raw = 1'b0;
        fwd = '0;
        rs  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rs = id_rs[k*REG_ADDR_W +: REG_ADDR_W];
            if (id_rs_valid[k] && rs != '0) begin
                if (!rdy_tab[rs]) begin
                    raw = 1'b1;
                end
`ifdef HAZARD_FORWARD_EN
                fwd[k] = pend_tab[rs] && rdy_tab[rs];
`endif
            end
        end
    end

    // A new write must not complete before an older one to the same register.
    assign waw = id_rd_valid && (id_rd != '0) && pend_tab[id_rd] &&
                 (varlat_tab[id_rd] || (id_lat == '0) || (cnt_tab[id_rd] >= id_lat));

    assign stall       = id_valid && !flush && (raw || waw);
    assign issue       = id_valid && !flush && !stall && id_rd_valid && (id_rd != '0);
    assign fwd_hit     = fwd;
    assign pending_vec = pend_tab;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// against a time-stamp based reference model. Honours HAZARD_FORWARD_EN like the design.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int unsigned NS = 2;
    localparam int unsigned W  = 5;
    localparam int unsigned NR = 32;
    localparam int unsigned CW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [NS*W-1:0]   id_rs;
    logic [NS-1:0]     id_rs_valid;
    logic [W-1:0]      id_rd;
    logic              id_rd_valid;
    logic [CW-1:0]     id_lat;
    logic              flush;
    logic              wb_valid;
    logic [W-1:0]      wb_rd;
    logic              stall;
    logic [NS-1:0]     fwd_hit;
    logic [NR-1:0]     pending_vec;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_SRC    (NS),
        .REG_ADDR_W (W),
        .NUM_REGS   (NR),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_valid (id_rs_valid),
        .id_rd       (id_rd),
        .id_rd_valid (id_rd_valid),
        .id_lat      (id_lat),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .stall       (stall),
        .fwd_hit     (fwd_hit),
        .pending_vec (pending_vec)
    );

    // Reference model: each pending register remembers the absolute cycle its value becomes forwardable.
    bit          m_pend [NR];
    bit          m_vl   [NR];
    longint      m_at   [NR];
    longint      now = 0;
    logic        exp_stall;
    logic [NS-1:0] exp_fwd;
    logic        exp_issue;
    logic [NR-1:0] exp_pvec;

    function automatic longint remaining(int r);
        return (m_at[r] > now) ? (m_at[r] - now) : 64'd0;
    endfunction

    function automatic bit m_ready(int r);
`ifdef HAZARD_FORWARD_EN
        return !m_pend[r] || (!m_vl[r] && remaining(r) == 0);
`else
        return !m_pend[r];
`endif
    endfunction

    function automatic void model_eval();
        bit haz;
        int rs;
        int rd;
        haz     = 1'b0;
        exp_fwd = '0;
        for (int k = 0; k < int'(NS); k++) begin
            rs = int'(id_rs[k*W +: W]);
            if (id_rs_valid[k] && rs != 0) begin
                if (!m_ready(rs)) haz = 1'b1;
`ifdef HAZARD_FORWARD_EN
                exp_fwd[k] = m_pend[rs] && m_ready(rs);
`endif
            end
        end
        rd = int'(id_rd);
        if (id_rd_valid && rd != 0 && m_pend[rd] &&
            (m_vl[rd] || id_lat == 0 || remaining(rd) >= longint'(id_lat)))
            haz = 1'b1;
        exp_stall = id_valid && !flush && haz;
        exp_issue = id_valid && !flush && !exp_stall && id_rd_valid && rd != 0;
        for (int r = 0; r < int'(NR); r++) exp_pvec[r] = m_pend[r];
    endfunction

    task automatic settle();
        #1;
        model_eval();
    endtask

    // Advance one clock and move the model across the same edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < int'(NR); r++) begin
                m_pend[r] = 1'b0; m_vl[r] = 1'b0; m_at[r] = 0;
            end
        end else begin
            if (wb_valid && wb_rd != 0) begin
                m_pend[int'(wb_rd)] = 1'b0; m_vl[int'(wb_rd)] = 1'b0;
            end
            if (exp_issue) begin
                m_pend[int'(id_rd)] = 1'b1;
                m_vl[int'(id_rd)]   = (id_lat == 0);
                m_at[int'(id_rd)]   = now + longint'(id_lat);
            end
        end
        now++;
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [W-1:0] r1, input logic v1,
                          input logic [W-1:0] r2, input logic v2,
                          input logic [W-1:0] rd, input logic rdv, input logic [CW-1:0] lat);
        id_valid    = v;
        id_rs       = {r2, r1};
        id_rs_valid = {v2, v1};
        id_rd       = rd;
        id_rd_valid = rdv;
        id_lat      = lat;
        flush       = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
    endtask

    task automatic idle();
        reset = 1'b0;
        set_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic retire(input logic [W-1:0] r);
        idle();
        wb_valid = 1'b1;
        wb_rd    = r;
        settle();
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_id(1'b1, '0, 1'b1, '0, 1'b1, '0, 1'b1, 3'd1);
        tick();
        tick();
        settle();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
        vectors++; if (pending_vec !== '0) begin miscompares++; $display("FAIL reset_pending: got %h want 0", pending_vec); end
        reset = 1'b0;
    endtask

    task automatic test_x0();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, '0, 1'b1, 3'd2);
        settle();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL x0_stall: got %b want 0", stall); end
        tick();
        idle();
        settle();
        vectors++; if (pending_vec !== '0) begin miscompares++; $display("FAIL x0_pending: got %h want 0", pending_vec); end
    endtask

    task automatic test_alu_back_to_back();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, 3'd1);
        settle();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu_issue: stall=%b want 0", stall); end
        tick();
        set_id(1'b1, 5'd5, 1'b1, '0, 1'b0, '0, 1'b0, '0);
        settle();
`ifdef HAZARD_FORWARD_EN
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu_dep_stall: got %b want 0", stall); end
        vectors++; if (fwd_hit !== 2'b01) begin miscompares++; $display("FAIL alu_dep_fwd: got %b want 01", fwd_hit); end
        tick();
        retire(5'd5);
`else
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL alu_dep_stall: got %b want 1", stall); end
        vectors++; if (fwd_hit !== 2'b00) begin miscompares++; $display("FAIL alu_dep_fwd: got %b want 00", fwd_hit); end
        tick();
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        settle();
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL alu_wb_cycle: stall=%b want 1", stall); end
        tick();
        wb_valid = 1'b0;
        settle();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu_after_wb: stall=%b want 0", stall); end
        tick();
        idle();
`endif
        settle();
        vectors++; if (pending_vec !== '0) begin miscompares++; $display("FAIL alu_clean: got %h want 0", pending_vec); end
    endtask

    task automatic test_load_use();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1, 3'd2);
        settle();
        tick();
        set_id(1'b1, '0, 1'b0, 5'd7, 1'b1, '0, 1'b0, '0);
        settle();
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL load_use_first: stall=%b want 1", stall); end
        tick();
        settle();
`ifdef HAZARD_FORWARD_EN
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL load_use_second: stall=%b want 0", stall); end
        vectors++; if (fwd_hit !== 2'b10) begin miscompares++; $display("FAIL load_use_fwd: got %b want 10", fwd_hit); end
`else
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL load_use_second: stall=%b want 1", stall); end
        vectors++; if (fwd_hit !== 2'b00) begin miscompares++; $display("FAIL load_use_fwd: got %b want 00", fwd_hit); end
`endif
        tick();
        retire(5'd7);
    endtask

    task automatic test_varlat();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd9, 1'b1, 3'd0);
        settle();
        tick();
        set_id(1'b1, 5'd9, 1'b1, '0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL varlat_wait[%0d]: stall=%b want 1", i, stall); end
            tick();
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        settle();
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL varlat_wb_cycle: stall=%b want 1", stall); end
        tick();
        wb_valid = 1'b0;
        settle();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL varlat_release: stall=%b want 0", stall); end
        vectors++; if (pending_vec[9] !== 1'b0) begin miscompares++; $display("FAIL varlat_pending: got %b want 0", pending_vec[9]); end
        tick();
        idle();
    endtask

    task automatic test_waw();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd3, 1'b1, 3'd3);
        settle();
        tick();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd3, 1'b1, 3'd1);
        for (int i = 0; i < 2; i++) begin
            settle();
            vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL waw_hold[%0d]: stall=%b want 1", i, stall); end
            tick();
        end
        settle();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL waw_release: stall=%b want 0", stall); end
        tick();
        set_id(1'b1, 5'd3, 1'b1, '0, 1'b0, '0, 1'b0, '0);
        settle();
        vectors++; if (pending_vec[3] !== 1'b1) begin miscompares++; $display("FAIL waw_reissue_pending: got %b want 1", pending_vec[3]); end
`ifdef HAZARD_FORWARD_EN
        vectors++; if (fwd_hit !== 2'b01) begin miscompares++; $display("FAIL waw_reissue_fwd: got %b want 01", fwd_hit); end
`else
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL waw_reissue_stall: got %b want 1", stall); end
`endif
        tick();
        retire(5'd3);
    endtask

    task automatic test_simultaneous();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd4, 1'b1, 3'd1);
        settle();
        tick();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd4, 1'b1, 3'd3);
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        settle();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL simul_stall: got %b want 0", stall); end
        tick();
        set_id(1'b1, 5'd4, 1'b1, '0, 1'b0, '0, 1'b0, '0);
        settle();
        vectors++; if (pending_vec[4] !== 1'b1) begin miscompares++; $display("FAIL simul_pending: got %b want 1", pending_vec[4]); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL simul_dep_cnt2: stall=%b want 1", stall); end
        tick();
        settle();
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL simul_dep_cnt1: stall=%b want 1", stall); end
        tick();
        settle();
`ifdef HAZARD_FORWARD_EN
        vectors++; if (fwd_hit !== 2'b01) begin miscompares++; $display("FAIL simul_dep_fwd: got %b want 01", fwd_hit); end
`else
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL simul_dep_nofwd: stall=%b want 1", stall); end
`endif
        tick();
        retire(5'd4);
    endtask

    task automatic test_flush();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd6, 1'b1, 3'd0);
        settle();
        tick();
        set_id(1'b1, 5'd6, 1'b1, '0, 1'b0, 5'd8, 1'b1, 3'd1);
        flush = 1'b1;
        settle();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick();
        settle();
        vectors++; if (pending_vec !== 32'h0000_0040) begin miscompares++; $display("FAIL flush_table: got %h want 00000040", pending_vec); end
        flush = 1'b0;
        settle();
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL flush_off_stall: got %b want 1", stall); end
        tick();
        retire(5'd6);
        settle();
        vectors++; if (pending_vec !== '0) begin miscompares++; $display("FAIL flush_clean: got %h want 0", pending_vec); end
    endtask

    task automatic test_reset_mid();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd10, 1'b1, 3'd0);
        settle();
        tick();
        set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd11, 1'b1, 3'd5);
        settle();
        tick();
        set_id(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, '0, 1'b0, '0);
        reset = 1'b1;
        settle();
        tick();
        reset = 1'b0;
        settle();
        vectors++; if (pending_vec !== '0) begin miscompares++; $display("FAIL reset_mid_pending: got %h want 0", pending_vec); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_mid_stall: got %b want 0", stall); end
        vectors++; if (fwd_hit !== 2'b00) begin miscompares++; $display("FAIL reset_mid_fwd: got %b want 00", fwd_hit); end
        tick();
        idle();
    endtask

    task automatic test_random_traffic();
        int q[$];
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs       = {W'($urandom_range(0, 7)), W'($urandom_range(0, 7))};
            id_rs_valid = NS'($urandom);
            id_rd       = W'($urandom_range(0, 7));
            id_rd_valid = ($urandom_range(0, 3) != 0);
            id_lat      = CW'($urandom);
            flush       = ($urandom_range(0, 9) == 0);
            q.delete();
            for (int r = 1; r < 8; r++) if (m_pend[r]) q.push_back(r);
            if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                wb_valid = 1'b1;
                wb_rd    = W'(q[$urandom_range(0, q.size() - 1)]);
            end else begin
                wb_valid = ($urandom_range(0, 3) == 0);
                wb_rd    = W'($urandom_range(0, 7));
            end
            settle();
            vectors++; if (stall !== exp_stall) begin miscompares++; $display("FAIL rand_stall[%0d]: got %b want %b", n, stall, exp_stall); end
            vectors++; if (fwd_hit !== exp_fwd) begin miscompares++; $display("FAIL rand_fwd[%0d]: got %b want %b", n, fwd_hit, exp_fwd); end
            vectors++; if (pending_vec !== exp_pvec) begin miscompares++; $display("FAIL rand_pending[%0d]: got %h want %h", n, pending_vec, exp_pvec); end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < int'(NR); r++) begin
            m_pend[r] = 1'b0; m_vl[r] = 1'b0; m_at[r] = 0;
        end
        idle();
        @(negedge clk);
        test_reset();
        test_x0();
        test_alu_back_to_back();
        test_load_use();
        test_varlat();
        test_waw();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
